// File: rtl/adder_3_qor_pkg.sv
`default_nettype none
// ============================================================================
// adder_3_qor_pkg: shared types and widths for the adder_3 QoR monitor
// Rev 1.0
// ============================================================================
package adder_3_qor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int c_op_w       = 3;
  localparam int c_sum_w      = 4;
  localparam int c_pipe_depth = 2;

endpackage
`default_nettype wire

// File: rtl/adder_3_qor_monitor_exact_ref.sv
`default_nettype none
// ============================================================================
// adder_3_exact_ref: exact combinational reference a + b + cin
// Rev 1.0
// ============================================================================
module adder_3_exact_ref
  import adder_3_qor_pkg::*;
(
  input  logic [c_op_w-1:0]  a,
  input  logic [c_op_w-1:0]  b,
  input  logic               cin,
  output logic [c_sum_w-1:0] sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {{(c_sum_w-1){1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/adder_3_qor_monitor.sv
`default_nettype none
// ============================================================================
// adder_3_qor_monitor: error statistics of approximate adder_3 over N_VEC beats
// Rev 1.0
// ============================================================================
module adder_3_qor_monitor
  import adder_3_qor_pkg::*;
#(
  parameter int N_VEC = 128,
  parameter int CNT_W = 16
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [c_op_w-1:0]  a,
  input  logic [c_op_w-1:0]  b,
  input  logic               cin,
  input  logic [c_sum_w-1:0] approx_sum,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   vec_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [c_sum_w-1:0] max_abs_err,
  output logic [CNT_W-1:0]   sum_abs_err
);

  localparam logic [CNT_W-1:0] c_last      = CNT_W'(N_VEC - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [1:0]       c_drain_end = 2'(c_pipe_depth - 1);

  state_t               r_state;
  logic [1:0]           r_drain;
  logic                 r_v1;
  logic                 r_v2;
  logic [c_sum_w-1:0]   r_exact1;
  logic [c_sum_w-1:0]   r_approx1;
  logic [c_sum_w-1:0]   r_abs2;
  logic                 r_mis2;
  logic [CNT_W-1:0]     r_vec;
  logic [CNT_W-1:0]     r_err;
  logic [CNT_W-1:0]     r_sum;
  logic [c_sum_w-1:0]   r_max;

  logic [c_sum_w-1:0]   w_exact;
  logic signed [c_sum_w:0] w_diff;
  logic [c_sum_w:0]     w_neg;
  logic [c_sum_w-1:0]   w_abs;
  logic [CNT_W:0]       w_sum_ext;
  logic                 w_accept;

  adder_3_exact_ref u_ref (
    .a   (a),
    .b   (b),
    .cin (cin),
    .sum (w_exact)
  );

  assign w_accept  = in_valid && (r_state == RUN);
  assign w_diff    = signed'({1'b0, r_approx1}) - signed'({1'b0, r_exact1});
  assign w_neg     = -w_diff;
  assign w_abs     = w_diff[c_sum_w] ? w_neg[c_sum_w-1:0] : w_diff[c_sum_w-1:0];
  // One spare bit catches the carry that signals saturation.
  assign w_sum_ext = {1'b0, r_sum} + {{(CNT_W+1-c_sum_w){1'b0}}, r_abs2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_drain   <= 2'd0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_exact1  <= '0;
      r_approx1 <= '0;
      r_abs2    <= '0;
      r_mis2    <= 1'b0;
      r_vec     <= '0;
      r_err     <= '0;
      r_sum     <= '0;
      r_max     <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_exact1  <= w_exact;
        r_approx1 <= approx_sum;
      end
      r_v2   <= r_v1;
      r_abs2 <= w_abs;
      r_mis2 <= (w_abs != '0);

      if (r_v2) begin
        if (r_mis2 && (r_err != c_cnt_max)) r_err <= r_err + CNT_W'(1);
        r_sum <= w_sum_ext[CNT_W] ? c_cnt_max : w_sum_ext[CNT_W-1:0];
        if (r_abs2 > r_max) r_max <= r_abs2;
      end

      // The start clear is placed after accumulation so it takes priority.
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            r_vec   <= '0;
            r_err   <= '0;
            r_sum   <= '0;
            r_max   <= '0;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_vec <= r_vec + CNT_W'(1);
            if (r_vec == c_last) begin
              r_state <= DRAIN;
              r_drain <= 2'd0;
            end
          end
        end
        DRAIN: begin
          if (r_drain == c_drain_end) r_state <= DONE;
          else                        r_drain <= r_drain + 2'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == RUN);
  assign busy        = (r_state == RUN) || (r_state == DRAIN);
  assign done        = (r_state == DONE);
  assign vec_count   = r_vec;
  assign err_count   = r_err;
  assign max_abs_err = r_max;
  assign sum_abs_err = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_adder_3_qor_monitor.sv
`default_nettype none
// ============================================================================
// tb_adder_3_qor_monitor: directed self-checking bench for adder_3_qor_monitor
// Rev 1.0
// ============================================================================
module tb_adder_3_qor_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instances 0/1/2 use N_VEC 4/2/3 with CNT_W 16.
  logic        rst_n[3];
  logic        start[3];
  logic        in_valid[3];
  logic        cin[3];
  logic [2:0]  a[3];
  logic [2:0]  b[3];
  logic [3:0]  approx[3];
  logic        in_ready[3];
  logic        busy[3];
  logic        done[3];
  logic [15:0] vec_count[3];
  logic [15:0] err_count[3];
  logic [15:0] sum_abs_err[3];
  logic [3:0]  max_abs_err[3];

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      adder_3_qor_monitor #(
        .N_VEC (k == 0 ? 4 : (k == 1 ? 2 : 3)),
        .CNT_W (16)
      ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n[k]),
        .start       (start[k]),
        .in_valid    (in_valid[k]),
        .in_ready    (in_ready[k]),
        .a           (a[k]),
        .b           (b[k]),
        .cin         (cin[k]),
        .approx_sum  (approx[k]),
        .busy        (busy[k]),
        .done        (done[k]),
        .vec_count   (vec_count[k]),
        .err_count   (err_count[k]),
        .max_abs_err (max_abs_err[k]),
        .sum_abs_err (sum_abs_err[k])
      );
    end
  endgenerate

  // Narrow-counter instance for saturation.
  logic       s_rst_n, s_start, s_valid, s_cin, s_ready, s_busy, s_done;
  logic [2:0] s_a, s_b;
  logic [3:0] s_approx, s_vec, s_err, s_sum, s_max;

  adder_3_qor_monitor #(.N_VEC(15), .CNT_W(4)) u_sat (
    .clk         (clk),
    .rst_n       (s_rst_n),
    .start       (s_start),
    .in_valid    (s_valid),
    .in_ready    (s_ready),
    .a           (s_a),
    .b           (s_b),
    .cin         (s_cin),
    .approx_sum  (s_approx),
    .busy        (s_busy),
    .done        (s_done),
    .vec_count   (s_vec),
    .err_count   (s_err),
    .max_abs_err (s_max),
    .sum_abs_err (s_sum)
  );

  logic [2:0] ref_a, ref_b;
  logic       ref_cin;
  logic [3:0] ref_sum;

  adder_3_exact_ref u_exact (
    .a   (ref_a),
    .b   (ref_b),
    .cin (ref_cin),
    .sum (ref_sum)
  );

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; start[k] = 1'b1; in_valid[k] = 1'b1;
      a[k] = 3'd7; b[k] = 3'd7; cin[k] = 1'b1; approx[k] = 4'd0;
    end
    s_rst_n = 1'b0; s_start = 1'b1; s_valid = 1'b1;
    s_a = 3'd7; s_b = 3'd7; s_cin = 1'b1; s_approx = 4'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({in_ready[k], busy[k], done[k]} !== 3'b000) begin
        n_err++; $display("FAIL reset_flags[%0d] got=%b exp=000", k, {in_ready[k], busy[k], done[k]});
      end
      n_vec++;
      if ({vec_count[k], err_count[k], sum_abs_err[k], max_abs_err[k]} !== 52'd0) begin
        n_err++; $display("FAIL reset_stats[%0d] vec=%0d err=%0d sum=%0d max=%0d exp all 0",
                          k, vec_count[k], err_count[k], sum_abs_err[k], max_abs_err[k]);
      end
    end
    n_vec++;
    if ({s_ready, s_busy, s_done, s_vec, s_err, s_sum, s_max} !== 19'd0) begin
      n_err++; $display("FAIL reset_sat got=%h exp=0", {s_ready, s_busy, s_done, s_vec, s_err, s_sum, s_max});
    end
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; in_valid[k] = 1'b0; rst_n[k] = 1'b1;
    end
    s_start = 1'b0; s_valid = 1'b0; s_rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy[0] !== 1'b0 || vec_count[0] !== 16'd0) begin
      n_err++; $display("FAIL reset_release busy=%b vec=%0d exp busy=0 vec=0", busy[0], vec_count[0]);
    end
  endtask

  task automatic test_clean();
    logic [2:0] ta[4] = '{3'd1, 3'd7, 3'd0, 3'd5};
    logic [2:0] tb[4] = '{3'd2, 3'd7, 3'd0, 3'd6};
    logic       tc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] tx[4] = '{4'd3, 4'd15, 4'd0, 4'd12};
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n_vec++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL clean_run_entry busy=%b ready=%b exp 1 1", busy[0], in_ready[0]);
    end
    for (int i = 0; i < 4; i++) begin
      a[0] = ta[i]; b[0] = tb[i]; cin[0] = tc[i]; approx[0] = tx[i]; in_valid[0] = 1'b1;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    n_vec++;
    if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1 || done[0] !== 1'b0 || vec_count[0] !== 16'd4) begin
      n_err++; $display("FAIL clean_drain ready=%b busy=%b done=%b vec=%0d exp 0 1 0 4",
                        in_ready[0], busy[0], done[0], vec_count[0]);
    end
    @(negedge clk);
    n_vec++;
    if (done[0] !== 1'b0) begin
      n_err++; $display("FAIL clean_done_early got=%b exp=0", done[0]);
    end
    @(negedge clk);
    n_vec++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_err++; $display("FAIL clean_done done=%b busy=%b exp 1 0", done[0], busy[0]);
    end
    n_vec++;
    if (vec_count[0] !== 16'd4 || err_count[0] !== 16'd0 || max_abs_err[0] !== 4'd0 || sum_abs_err[0] !== 16'd0) begin
      n_err++; $display("FAIL clean_stats vec=%0d err=%0d max=%0d sum=%0d exp 4 0 0 0",
                        vec_count[0], err_count[0], max_abs_err[0], sum_abs_err[0]);
    end
  endtask

  task automatic test_errors();
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    a[1] = 3'd3; b[1] = 3'd2; cin[1] = 1'b1; approx[1] = 4'd4; in_valid[1] = 1'b1;
    @(negedge clk);
    a[1] = 3'd7; b[1] = 3'd7; cin[1] = 1'b1; approx[1] = 4'd0;
    @(negedge clk);
    in_valid[1] = 1'b0;
    n_vec++;
    if (err_count[1] !== 16'd0 || busy[1] !== 1'b1 || in_ready[1] !== 1'b0) begin
      n_err++; $display("FAIL err_latency1 err=%0d busy=%b ready=%b exp 0 1 0", err_count[1], busy[1], in_ready[1]);
    end
    @(negedge clk);
    n_vec++;
    if (err_count[1] !== 16'd1 || sum_abs_err[1] !== 16'd2 || max_abs_err[1] !== 4'd2 || done[1] !== 1'b0) begin
      n_err++; $display("FAIL err_first_beat err=%0d sum=%0d max=%0d done=%b exp 1 2 2 0",
                        err_count[1], sum_abs_err[1], max_abs_err[1], done[1]);
    end
    @(negedge clk);
    n_vec++;
    if (err_count[1] !== 16'd2 || sum_abs_err[1] !== 16'd17 || max_abs_err[1] !== 4'd15 ||
        done[1] !== 1'b1 || vec_count[1] !== 16'd2) begin
      n_err++; $display("FAIL err_final err=%0d sum=%0d max=%0d done=%b vec=%0d exp 2 17 15 1 2",
                        err_count[1], sum_abs_err[1], max_abs_err[1], done[1], vec_count[1]);
    end
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    n_vec++;
    if (done[1] !== 1'b0 || busy[1] !== 1'b1 || err_count[1] !== 16'd0 || sum_abs_err[1] !== 16'd0 ||
        max_abs_err[1] !== 4'd0 || vec_count[1] !== 16'd0) begin
      n_err++; $display("FAIL restart_clear done=%b busy=%b err=%0d sum=%0d max=%0d vec=%0d exp 0 1 0 0 0 0",
                        done[1], busy[1], err_count[1], sum_abs_err[1], max_abs_err[1], vec_count[1]);
    end
  endtask

  task automatic test_bubbles();
    logic [2:0] ta[3] = '{3'd2, 3'd4, 3'd6};
    logic [2:0] tb[3] = '{3'd3, 3'd4, 3'd1};
    logic       tc[3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] tx[3] = '{4'd5, 4'd12, 4'd1};
    logic [3:0] te[3] = '{4'd5, 4'd9, 4'd7};
    for (int j = 0; j < 3; j++) begin
      ref_a = ta[j]; ref_b = tb[j]; ref_cin = tc[j];
      #1;
      n_vec++;
      if (ref_sum !== te[j]) begin
        n_err++; $display("FAIL exact_ref[%0d] got=%0d exp=%0d", j, ref_sum, te[j]);
      end
    end
    @(negedge clk);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid[2] = (c % 2 == 0);
      start[2]    = (c == 1);
      a[2] = ta[c/2]; b[2] = tb[c/2]; cin[2] = tc[c/2]; approx[2] = tx[c/2];
      @(negedge clk);
      n_vec++;
      if (vec_count[2] !== 16'(c/2 + 1) || in_ready[2] !== (c < 4)) begin
        n_err++; $display("FAIL bubble_count[%0d] vec=%0d ready=%b exp vec=%0d ready=%b",
                          c, vec_count[2], in_ready[2], c/2 + 1, (c < 4));
      end
    end
    in_valid[2] = 1'b0; start[2] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (done[2] !== 1'b0 || busy[2] !== 1'b1) begin
      n_err++; $display("FAIL bubble_drain done=%b busy=%b exp 0 1", done[2], busy[2]);
    end
    @(negedge clk);
    n_vec++;
    if (done[2] !== 1'b1 || vec_count[2] !== 16'd3 || err_count[2] !== 16'd2 ||
        max_abs_err[2] !== 4'd6 || sum_abs_err[2] !== 16'd9) begin
      n_err++; $display("FAIL bubble_stats done=%b vec=%0d err=%0d max=%0d sum=%0d exp 1 3 2 6 9",
                        done[2], vec_count[2], err_count[2], max_abs_err[2], sum_abs_err[2]);
    end
  endtask

  task automatic test_saturation();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      s_valid = 1'b1;
      if (i % 2 == 0) begin s_a = 3'd0; s_b = 3'd0; s_cin = 1'b0; s_approx = 4'd15; end
      else            begin s_a = 3'd7; s_b = 3'd7; s_cin = 1'b1; s_approx = 4'd0;  end
      @(negedge clk);
      if (i == 3) begin
        n_vec++;
        if (s_sum !== 4'd15 || s_err !== 4'd2) begin
          n_err++; $display("FAIL sat_early sum=%0d err=%0d exp 15 2", s_sum, s_err);
        end
      end
    end
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (s_done !== 1'b1 || s_vec !== 4'd15 || s_err !== 4'd15 || s_sum !== 4'd15 || s_max !== 4'd15) begin
      n_err++; $display("FAIL sat_final done=%b vec=%0d err=%0d sum=%0d max=%0d exp 1 15 15 15 15",
                        s_done, s_vec, s_err, s_sum, s_max);
    end
  endtask

  task automatic test_reset_midrun();
    logic [2:0] ta[4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic [2:0] tb[4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic       tc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] tx[4] = '{4'd3, 4'd4, 4'd0, 4'd1};
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a[0] = 3'd7; b[0] = 3'd7; cin[0] = 1'b1; approx[0] = 4'd0; in_valid[0] = 1'b1;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    n_vec++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      n_err++; $display("FAIL midrun_in_drain busy=%b ready=%b exp 1 0", busy[0], in_ready[0]);
    end
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    n_vec++;
    if ({in_ready[0], busy[0], done[0]} !== 3'b000 || vec_count[0] !== 16'd0 || err_count[0] !== 16'd0 ||
        sum_abs_err[0] !== 16'd0 || max_abs_err[0] !== 4'd0) begin
      n_err++; $display("FAIL midrun_reset flags=%b vec=%0d err=%0d sum=%0d max=%0d exp 000 0 0 0 0",
                        {in_ready[0], busy[0], done[0]}, vec_count[0], err_count[0], sum_abs_err[0], max_abs_err[0]);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (err_count[0] !== 16'd0 || sum_abs_err[0] !== 16'd0 || busy[0] !== 1'b0) begin
      n_err++; $display("FAIL midrun_discard err=%0d sum=%0d busy=%b exp 0 0 0", err_count[0], sum_abs_err[0], busy[0]);
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a[0] = ta[i]; b[0] = tb[i]; cin[0] = tc[i]; approx[0] = tx[i]; in_valid[0] = 1'b1;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (done[0] !== 1'b1 || vec_count[0] !== 16'd4 || err_count[0] !== 16'd2 ||
        max_abs_err[0] !== 4'd7 || sum_abs_err[0] !== 16'd8) begin
      n_err++; $display("FAIL midrun_fresh done=%b vec=%0d err=%0d max=%0d sum=%0d exp 1 4 2 7 8",
                        done[0], vec_count[0], err_count[0], max_abs_err[0], sum_abs_err[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ref_a = 3'd0; ref_b = 3'd0; ref_cin = 1'b0;
    test_reset();
    test_clean();
    test_errors();
    test_bubbles();
    test_saturation();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
